// File: rtl/weight_mem_ctrl_if.sv
// Bundle of load, run and memory-side signals for weight_mem_ctrl.
// slave is the controller view; master is the host / neuron-array view.
interface weight_mem_ctrl_if #(
  parameter int unsigned numNeuron    = 30,
  parameter int unsigned addressWidth = 10,
  parameter int unsigned dataWidth    = 16,
  parameter int unsigned neuronWidth  = 5
);
  logic                    ld_start;
  logic [neuronWidth-1:0]  ld_neuron;
  logic                    ld_valid;
  logic [dataWidth-1:0]    ld_data;
  logic                    ld_ready;
  logic                    ld_done;
  logic                    ld_err;
  logic                    run_start;
  logic                    run_stall;
  logic                    run_done;
  logic                    busy;
  logic [numNeuron-1:0]    wen;
  logic [addressWidth-1:0] wadd;
  logic [dataWidth-1:0]    win;
  logic                    ren;
  logic [addressWidth-1:0] radd;
  logic                    w_valid;
  logic                    w_last;

  modport slave (
    input  ld_start, ld_neuron, ld_valid, ld_data, run_start, run_stall,
    output ld_ready, ld_done, ld_err, run_done, busy, wen, wadd, win, ren, radd,
    output w_valid, w_last
  );

  modport master (
    output ld_start, ld_neuron, ld_valid, ld_data, run_start, run_stall,
    input  ld_ready, ld_done, ld_err, run_done, busy, wen, wadd, win, ren, radd,
    input  w_valid, w_last
  );
endinterface

// File: rtl/weight_mem_ctrl.sv
// Weight memory sequencer: loads one neuron's memory, or replays all addresses to the array.
// Define PRETRAINED_WEIGHTS_EN to remove the load path (weights built into the memories).
module weight_mem_ctrl #(
  parameter int unsigned numWeight    = 784,
  parameter int unsigned numNeuron    = 30,
  parameter int unsigned addressWidth = 10,
  parameter int unsigned dataWidth    = 16,
  parameter int unsigned neuronWidth  = 5
) (
  input logic               clk,
  input logic               rst,
  weight_mem_ctrl_if.slave  bus
);

  localparam logic [addressWidth-1:0] LastAddr = addressWidth'(numWeight - 1);

`ifdef PRETRAINED_WEIGHTS_EN
  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} state_e;
`endif

  state_e                  r_state, w_state_d;
  logic                    w_ld_ok, w_ld_bad;
  logic                    w_ld_ready, w_ren, w_busy;
  logic [addressWidth-1:0] w_radd, r_rcnt;
  logic                    r_w_valid, r_w_last, r_ld_err;

`ifdef PRETRAINED_WEIGHTS_EN
  assign w_ld_ok  = 1'b0;
  assign w_ld_bad = bus.ld_start;
`else
  localparam logic [neuronWidth:0] NeuronLim = (neuronWidth + 1)'(numNeuron);

  logic                    w_hs;
  logic [numNeuron-1:0]    w_onehot;
  logic [neuronWidth-1:0]  r_sel;
  logic [addressWidth-1:0] r_wcnt, r_wadd;
  logic [numNeuron-1:0]    r_wen;
  logic [dataWidth-1:0]    r_win;
  logic                    r_ld_done;

  // Out-of-range neurons are flagged in every state; only IDLE acts on a valid one.
  assign w_ld_ok  = bus.ld_start && ({1'b0, bus.ld_neuron} < NeuronLim);
  assign w_ld_bad = bus.ld_start && !w_ld_ok;
  assign w_hs     = bus.ld_valid && w_ld_ready;
  assign w_onehot = numNeuron'(1) << r_sel;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_ld_ok)            w_state_d = state_e'(1);
        else if (bus.run_start) w_state_d = StRun;
      end
`ifndef PRETRAINED_WEIGHTS_EN
      StLoad:  if (w_hs && (r_wcnt == LastAddr)) w_state_d = StIdle;
`endif
      StRun:   if (w_ren && (r_rcnt == LastAddr)) w_state_d = StDrain;
      StDrain: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_ld_ready = 1'b0;
    w_ren      = 1'b0;
    w_radd     = '0;
    w_busy     = (r_state != StIdle);
    unique case (r_state)
`ifndef PRETRAINED_WEIGHTS_EN
      StLoad: w_ld_ready = 1'b1;
`endif
      StRun: begin
        w_ren  = !bus.run_stall;
        w_radd = r_rcnt;
      end
      default: ;
    endcase
  end

  // Read side: w_valid/w_last trail the issued read by the memory's one-cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcnt    <= '0;
      r_w_valid <= 1'b0;
      r_w_last  <= 1'b0;
      r_ld_err  <= 1'b0;
    end else begin
      r_ld_err  <= w_ld_bad;
      r_w_valid <= w_ren;
      r_w_last  <= w_ren && (r_rcnt == LastAddr);
      if (r_state == StIdle && w_state_d == StRun) r_rcnt <= '0;
      else if (w_ren && (r_rcnt != LastAddr))      r_rcnt <= r_rcnt + 1'b1;
    end
  end

`ifndef PRETRAINED_WEIGHTS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel     <= '0;
      r_wcnt    <= '0;
      r_wen     <= '0;
      r_wadd    <= '0;
      r_win     <= '0;
      r_ld_done <= 1'b0;
    end else begin
      r_wen     <= w_hs ? w_onehot : '0;
      r_ld_done <= w_hs && (r_wcnt == LastAddr);
      if (w_hs) begin
        r_wadd <= r_wcnt;
        r_win  <= bus.ld_data;
      end
      if (r_state == StIdle && w_ld_ok) begin
        r_sel  <= bus.ld_neuron;
        r_wcnt <= '0;
      end else if (w_hs && (r_wcnt != LastAddr)) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
    end
  end

  assign bus.wen      = r_wen;
  assign bus.wadd     = r_wadd;
  assign bus.win      = r_win;
  assign bus.ld_done  = r_ld_done;
  assign bus.ld_ready = w_ld_ready;
`else
  assign bus.wen      = '0;
  assign bus.wadd     = '0;
  assign bus.win      = '0;
  assign bus.ld_done  = 1'b0;
  assign bus.ld_ready = 1'b0;
`endif

  assign bus.ld_err   = r_ld_err;
  assign bus.busy     = w_busy;
  assign bus.ren      = w_ren;
  assign bus.radd     = w_radd;
  assign bus.w_valid  = r_w_valid;
  assign bus.w_last   = r_w_last;
  assign bus.run_done = r_w_last;

endmodule
